// File: rtl/semaforo_pkg.sv
// Shared types and constants for the semaforo traffic-light controller.
// Lamp codes are one-hot so each bit drives one lamp driver directly.
package semaforo_pkg;

    typedef enum logic [1:0] {
        A_GRN,
        A_YEL,
        B_GRN,
        B_YEL
    } state_t;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    // A zero phase length behaves as one cycle, so both 0 and 1 load zero.
    function automatic logic [7:0] phase_load(input logic [7:0] len);
        return (len == 8'd0) ? 8'd0 : len - 8'd1;
    endfunction

endpackage

// File: rtl/semaforo_timer.sv
// 8-bit loadable down counter holding the remaining cycles-1 of the current phase.
// It stops at zero and raises the zero flag.
module semaforo_timer #(
    parameter logic [7:0] RESET_VAL = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= RESET_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign zero = (cnt == 8'd0);

endmodule

// File: rtl/semaforo.sv
// Two-way traffic-light controller. Light A is the main road and light B the cross road.
// The button bt cuts A's green phase short.
module semaforo
    import semaforo_pkg::*;
#(
    parameter logic [7:0] T_GREEN  = 8'd3,
    parameter logic [7:0] T_YELLOW = 8'd1,
    parameter logic [7:0] T_RED    = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt,
    output logic [2:0] A,
    output logic [2:0] B
);

    localparam logic [7:0] GREEN_LOAD  = phase_load(T_GREEN);
    localparam logic [7:0] YELLOW_LOAD = phase_load(T_YELLOW);
    localparam logic [7:0] RED_LOAD    = phase_load(T_RED);

    state_t     state;
    state_t     next_state;
    logic       load;
    logic [7:0] load_val;
    logic       zero;

    semaforo_timer #(
        .RESET_VAL (GREEN_LOAD)
    ) timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= A_GRN;
        end else begin
            state <= next_state;
        end
    end

    // Each phase change reloads the timer with the length of the phase being entered.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_val   = GREEN_LOAD;
        case (state)
            A_GRN: begin
                if (bt || zero) begin
                    next_state = A_YEL;
                    load       = 1'b1;
                    load_val   = YELLOW_LOAD;
                end
            end
            A_YEL: begin
                if (zero) begin
                    next_state = B_GRN;
                    load       = 1'b1;
                    load_val   = RED_LOAD;
                end
            end
            B_GRN: begin
                if (zero) begin
                    next_state = B_YEL;
                    load       = 1'b1;
                    load_val   = YELLOW_LOAD;
                end
            end
            B_YEL: begin
                if (zero) begin
                    next_state = A_GRN;
                    load       = 1'b1;
                    load_val   = GREEN_LOAD;
                end
            end
            default: begin
                next_state = A_GRN;
                load       = 1'b1;
                load_val   = GREEN_LOAD;
            end
        endcase
    end

    always_comb begin
        A = LAMP_RED;
        B = LAMP_RED;
        case (state)
            A_GRN:   A = LAMP_GREEN;
            A_YEL:   A = LAMP_YELLOW;
            B_GRN:   B = LAMP_GREEN;
            B_YEL:   B = LAMP_YELLOW;
            default: begin
                A = LAMP_RED;
                B = LAMP_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_semaforo.sv
// Testbench for semaforo. It runs three parameterisations side by side against a phase/elapsed model.
// The three sets are the defaults, long phases of 255/1/255, and all-zero lengths that clamp to 1.
`timescale 1ns/1ps
module tb_semaforo;

    logic clk;
    logic clk_en;
    logic rst;
    logic bt;
    logic [2:0][2:0] a_out;
    logic [2:0][2:0] b_out;

    int vectors;
    int miscompares;

    // The model keeps the phase index and the cycles already spent in it.
    int phase   [3];
    int elapsed [3];
    int dur     [3][4] = '{'{3, 1, 2, 1}, '{255, 1, 255, 1}, '{1, 1, 1, 1}};
    logic [2:0] lamp_a [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
    logic [2:0] lamp_b [4] = '{3'b100, 3'b100, 3'b001, 3'b010};

    semaforo dut0 (.clk(clk), .rst(rst), .bt(bt), .A(a_out[0]), .B(b_out[0]));

    semaforo #(.T_GREEN(8'd255), .T_YELLOW(8'd1), .T_RED(8'd255)) dut1 (
        .clk(clk), .rst(rst), .bt(bt), .A(a_out[1]), .B(b_out[1]));

    semaforo #(.T_GREEN(8'd0), .T_YELLOW(8'd0), .T_RED(8'd0)) dut2 (
        .clk(clk), .rst(rst), .bt(bt), .A(a_out[2]), .B(b_out[2]));

    always #5 if (clk_en) clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            phase[k]   = 0;
            elapsed[k] = 0;
        end
    endtask

    // One rising edge; the model follows the sampled bt/rst, then outputs settle for checking.
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                if (phase[k] == 0 && bt) begin
                    phase[k]   = 1;
                    elapsed[k] = 0;
                end else begin
                    elapsed[k]++;
                    if (elapsed[k] >= dur[k][phase[k]]) begin
                        phase[k]   = (phase[k] + 1) % 4;
                        elapsed[k] = 0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        bt  = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (a_out[k] !== 3'b001 || b_out[k] !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL reset dut%0d: A=%b B=%b, required A=001 B=100", k, a_out[k], b_out[k]);
            end
        end
    endtask

    // The clock is held high while bt pulses; nothing may move.
    task automatic test_no_clock();
        rst = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            bt = (t == 1 || t == 7) ? 1'b1 : 1'b0;
            #1;
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (a_out[k] !== 3'b001 || b_out[k] !== 3'b100) begin
                    miscompares++;
                    $display("[TB] FAIL no_clock t=%0d dut%0d: A=%b B=%b, required A=001 B=100", t, k, a_out[k], b_out[k]);
                end
            end
        end
        bt = 1'b0;
    endtask

    task automatic test_defaults();
        int seq [7] = '{0, 0, 1, 2, 2, 3, 0};
        apply_reset();
        for (int i = 1; i <= 14; i++) begin
            advance();
            vectors++;
            if (a_out[0] !== lamp_a[seq[(i - 1) % 7]] || b_out[0] !== lamp_b[seq[(i - 1) % 7]]) begin
                miscompares++;
                $display("[TB] FAIL defaults edge%0d: A=%b B=%b, required A=%b B=%b", i, a_out[0], b_out[0],
                         lamp_a[seq[(i - 1) % 7]], lamp_b[seq[(i - 1) % 7]]);
            end
            for (int k = 1; k < 3; k++) begin
                vectors++;
                if (a_out[k] !== lamp_a[phase[k]] || b_out[k] !== lamp_b[phase[k]]) begin
                    miscompares++;
                    $display("[TB] FAIL defaults dut%0d edge%0d: A=%b B=%b, required A=%b B=%b", k, i,
                             a_out[k], b_out[k], lamp_a[phase[k]], lamp_b[phase[k]]);
                end
            end
        end
    endtask

    task automatic test_button();
        apply_reset();
        bt = 1'b1;
        advance();
        bt = 1'b0;
        vectors++;
        if (a_out[0] !== 3'b010 || b_out[0] !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL button_cut: A=%b B=%b, required A=010 B=100", a_out[0], b_out[0]);
        end
        for (int i = 0; i < 4; i++) begin
            advance();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (a_out[k] !== lamp_a[phase[k]] || b_out[k] !== lamp_b[phase[k]]) begin
                    miscompares++;
                    $display("[TB] FAIL button dut%0d step%0d: A=%b B=%b, required A=%b B=%b", k, i,
                             a_out[k], b_out[k], lamp_a[phase[k]], lamp_b[phase[k]]);
                end
            end
        end
    endtask

    // bt is only raised when the default controller is outside A green, so its timing must not change.
    task automatic test_bt_ignored();
        int seq [7] = '{0, 0, 1, 2, 2, 3, 0};
        apply_reset();
        for (int i = 1; i <= 28; i++) begin
            bt = (phase[0] != 0) ? 1'($urandom_range(1, 0)) : 1'b0;
            advance();
            vectors++;
            if (a_out[0] !== lamp_a[seq[(i - 1) % 7]] || b_out[0] !== lamp_b[seq[(i - 1) % 7]]) begin
                miscompares++;
                $display("[TB] FAIL bt_ignored edge%0d: A=%b B=%b, required A=%b B=%b", i, a_out[0], b_out[0],
                         lamp_a[seq[(i - 1) % 7]], lamp_b[seq[(i - 1) % 7]]);
            end
        end
        bt = 1'b0;
    endtask

    task automatic test_async_reset_mid_phase();
        int budget;
        apply_reset();
        budget = 0;
        while (phase[0] != 2 && budget < 20) begin
            advance();
            budget++;
        end
        vectors++;
        if (phase[0] != 2 || a_out[0] !== 3'b100 || b_out[0] !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL reach_b_grn: A=%b B=%b after %0d edges, required A=100 B=001", a_out[0], b_out[0], budget);
        end
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (a_out[k] !== 3'b001 || b_out[k] !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL async_reset dut%0d: A=%b B=%b, required A=001 B=100", k, a_out[k], b_out[k]);
            end
        end
        advance();
        vectors++;
        if (a_out[0] !== 3'b001 || b_out[0] !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: A=%b B=%b, required A=001 B=100", a_out[0], b_out[0]);
        end
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            advance();
            vectors++;
            if (a_out[0] !== ((i < 3) ? 3'b001 : 3'b010)) begin
                miscompares++;
                $display("[TB] FAIL post_reset edge%0d: A=%b, required A=%b", i, a_out[0], (i < 3) ? 3'b001 : 3'b010);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bt = ($urandom_range(7, 0) == 0) ? 1'b1 : 1'b0;
            advance();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (a_out[k] !== lamp_a[phase[k]] || b_out[k] !== lamp_b[phase[k]]) begin
                    miscompares++;
                    $display("[TB] FAIL random dut%0d step%0d: A=%b B=%b, required A=%b B=%b", k, i,
                             a_out[k], b_out[k], lamp_a[phase[k]], lamp_b[phase[k]]);
                end
            end
        end
        bt = 1'b0;
    endtask

    // A full long-phase cycle is 512 edges; also count dut1's first green run directly.
    task automatic test_long_phases();
        int green_run;
        apply_reset();
        green_run = 1;
        for (int i = 0; i < 600; i++) begin
            advance();
            if (i == green_run - 1 && a_out[1] === 3'b001) begin
                green_run++;
            end
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (a_out[k] !== lamp_a[phase[k]] || b_out[k] !== lamp_b[phase[k]]) begin
                    miscompares++;
                    $display("[TB] FAIL long dut%0d step%0d: A=%b B=%b, required A=%b B=%b", k, i,
                             a_out[k], b_out[k], lamp_a[phase[k]], lamp_b[phase[k]]);
                end
            end
        end
        vectors++;
        if (green_run != 255) begin
            miscompares++;
            $display("[TB] FAIL long_green_len: got %0d cycles, required 255", green_run);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk         = 1'b1;
        clk_en      = 1'b0;
        rst         = 1'b0;
        bt          = 1'b0;
        test_reset();
        test_no_clock();
        clk_en = 1'b1;
        test_defaults();
        test_button();
        test_bt_ignored();
        test_async_reset_mid_phase();
        test_random();
        test_long_phases();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
